// File: rtl/keypad_scan_4x4.sv
// rtl/keypad_scan_4x4.sv - 4x4 matrix keypad row scanner with press/release debounce
// One key is tracked at a time; rollover is deliberately not supported.
module keypad_scan_4x4 #(
  parameter logic [19:0] T_SCAN = 20'd50_000,
  parameter logic [19:0] T_DB   = 20'd1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row_n,
  input  logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t      state, state_nxt;
  logic [19:0] cnt, cnt_nxt;
  logic [1:0]  r, r_nxt;
  logic [1:0]  c, c_nxt;
  logic [3:0]  sync_q, col_s;
  logic [3:0]  code_nxt;
  logic        valid_nxt, down_nxt;
  logic [1:0]  low_idx;
  logic        col_up, scan_end, db_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 4'hF;
      col_s  <= 4'hF;
    end else begin
      sync_q <= col_n;
      col_s  <= sync_q;
    end
  end

  assign row_n    = ~(4'b0001 << r);
  assign col_up   = col_s[c];
  assign scan_end = (cnt == T_SCAN - 20'd1);
  assign db_end   = (cnt == T_DB - 20'd1);

  // lowest-index low column wins when several keys share the row
  always_comb begin
    low_idx = 2'd3;
    if (!col_s[0])      low_idx = 2'd0;
    else if (!col_s[1]) low_idx = 2'd1;
    else if (!col_s[2]) low_idx = 2'd2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      cnt       <= 20'd0;
      r         <= 2'd0;
      c         <= 2'd0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      r         <= r_nxt;
      c         <= c_nxt;
      key_code  <= code_nxt;
      key_valid <= valid_nxt;
      key_down  <= down_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 20'd1;
    r_nxt     = r;
    c_nxt     = c;
    code_nxt  = key_code;
    valid_nxt = 1'b0;
    down_nxt  = key_down;
    case (state)
      SCAN: begin
        if (scan_end) begin
          cnt_nxt = 20'd0;
          if (&col_s) begin
            r_nxt = r + 2'd1;
          end else begin
            c_nxt     = low_idx;
            state_nxt = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (col_up) begin
          state_nxt = SCAN;
          cnt_nxt   = 20'd0;
        end else if (db_end) begin
          state_nxt = PRESSED;
          cnt_nxt   = 20'd0;
          code_nxt  = {r, c};
          valid_nxt = 1'b1;
          down_nxt  = 1'b1;
        end
      end
      PRESSED: begin
        cnt_nxt = 20'd0;
        if (col_up) state_nxt = RELEASE;
      end
      RELEASE: begin
        // a short release glitch returns to PRESSED without a second strobe
        if (!col_up) begin
          state_nxt = PRESSED;
          cnt_nxt   = 20'd0;
        end else if (db_end) begin
          state_nxt = SCAN;
          cnt_nxt   = 20'd0;
          r_nxt     = r + 2'd1;
          down_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = SCAN;
        cnt_nxt   = 20'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// tb/tb_keypad_scan_4x4.sv - self-checking bench for keypad_scan_4x4
// A keypad model closes the loop from row_n to col_n; key strobes go through a scoreboard.
module tb_keypad_scan_4x4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic [15:0] keys = 16'h0000;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [3:0] sb[$];
  logic prev_kv = 1'b0;

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  row_n;
    logic        kv;
    logic        kd;
  } vec_t;
  vec_t vecs[$];

  keypad_scan_4x4 #(.T_SCAN(20'd4), .T_DB(20'd8)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_n = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (!row_n[rr] && keys[rr*4+cc]) col_n[cc] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_kv <= 1'b0;
    end else begin
      if (key_valid) begin
        chk("kv_width", {31'd0, prev_kv}, 32'd0);
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL kv_unexpected: got key_valid code %0h expected none at %0t", key_code, $time);
        end else begin
          chk("kv_code", {28'd0, key_code}, {28'd0, sb.pop_front()});
        end
      end
      prev_kv <= key_valid;
    end
  end

  task automatic apply_vecs(input int lo, input int hi, input string name);
    for (int i = lo; i <= hi; i++) begin
      keys = vecs[i].keys;
      chk({name, "_row_n"}, {28'd0, row_n}, {28'd0, vecs[i].row_n});
      chk({name, "_kv"}, {31'd0, key_valid}, {31'd0, vecs[i].kv});
      chk({name, "_kd"}, {31'd0, key_down}, {31'd0, vecs[i].kd});
      step();
    end
  endtask

  task automatic wait_kv(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (key_valid) return;
      step();
    end
    n_cmp++;
    n_fail++;
    $display("FAIL %s_timeout: got no key_valid expected one within %0d cycles", name, budget);
  endtask

  task automatic wait_row0(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (row_n == 4'b1110) return;
      step();
    end
    n_cmp++;
    n_fail++;
    $display("FAIL row0_timeout: got row_n %b expected 1110 within %0d cycles", row_n, budget);
  endtask

  initial begin
    // idle scan: 40 cycles, each row held 4 cycles
    for (int i = 0; i < 40; i++)
      vecs.push_back('{16'h0000, ~(4'b0001 << ((i / 4) % 4)), 1'b0, 1'b0});
    // bounce on row0/col3: low 3, high 1, low 3, then high
    for (int i = 0; i < 11; i++)
      vecs.push_back('{(i < 3 || (i >= 4 && i < 7)) ? 16'h0008 : 16'h0000,
                       (i < 10) ? 4'b1110 : 4'b1101, 1'b0, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_row_n", {28'd0, row_n}, 32'he);
    chk("rst_code", {28'd0, key_code}, 32'h0);
    chk("rst_kv", {31'd0, key_valid}, 32'd0);
    chk("rst_kd", {31'd0, key_down}, 32'd0);
    rst = 1'b0;
    apply_vecs(0, 39, "scan");

    // press row2/col1 and hold
    sb.push_back(4'h9);
    keys = 16'h0200;
    wait_kv(80, "k9");
    chk("k9_code", {28'd0, key_code}, 32'h9);
    chk("k9_kd", {31'd0, key_down}, 32'd1);
    chk("k9_row", {28'd0, row_n}, 32'hb);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("k9_hold_row", {28'd0, row_n}, 32'hb);
      chk("k9_hold_kd", {31'd0, key_down}, 32'd1);
    end

    // clean release: key_down drops exactly 11 cycles later (2 sync + 8 debounce + 1)
    keys = 16'h0000;
    for (int i = 0; i <= 10; i++) begin
      chk("rel_kd_hi", {31'd0, key_down}, 32'd1);
      chk("rel_row_hold", {28'd0, row_n}, 32'hb);
      step();
    end
    chk("rel_kd_lo", {31'd0, key_down}, 32'd0);
    chk("rel_row_next", {28'd0, row_n}, 32'h7);
    chk("rel_code_hold", {28'd0, key_code}, 32'h9);

    wait_row0(40);
    apply_vecs(40, 50, "bounce");

    // press row1/col0, 2-cycle release glitch, then clean release
    sb.push_back(4'h4);
    keys = 16'h0010;
    wait_kv(80, "k4");
    chk("k4_code", {28'd0, key_code}, 32'h4);
    chk("k4_kd", {31'd0, key_down}, 32'd1);
    step();
    step();
    for (int i = 0; i < 12; i++) begin
      keys = (i == 0 || i == 1) ? 16'h0000 : 16'h0010;
      chk("glitch_kd", {31'd0, key_down}, 32'd1);
      step();
    end
    keys = 16'h0000;
    for (int i = 0; i < 30 && key_down; i++) step();
    chk("k4_rel_kd", {31'd0, key_down}, 32'd0);
    chk("k4_rel_row", {28'd0, row_n}, 32'hb);

    // row3 cols 2 and 0 together: lowest column wins
    sb.push_back(4'hC);
    keys = 16'h5000;
    wait_kv(80, "kc");
    chk("kc_code", {28'd0, key_code}, 32'hc);
    chk("kc_row", {28'd0, row_n}, 32'h7);
    step();
    step();
    chk("kc_pressed_kd", {31'd0, key_down}, 32'd1);

    // asynchronous reset mid-cycle while PRESSED
    #3;
    rst = 1'b1;
    #1;
    chk("arst_row_n", {28'd0, row_n}, 32'he);
    chk("arst_code", {28'd0, key_code}, 32'h0);
    chk("arst_kv", {31'd0, key_valid}, 32'd0);
    chk("arst_kd", {31'd0, key_down}, 32'd0);
    keys = 16'h0000;
    repeat (3) step();
    rst = 1'b0;
    chk("post_rst_row_n", {28'd0, row_n}, 32'he);
    repeat (60) step();
    chk("post_rst_kd", {31'd0, key_down}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
